// File: rtl/coeff_collect_if.sv
// Parse-word input stream and accepted-coefficient output stream of coeff_collect.
interface coeff_collect_if;
    logic        in_valid;
    logic [71:0] coeff_in;
    logic [5:0]  lane_ok;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_coeff;
    logic [7:0]  out_idx;

    modport master (
        output in_valid, coeff_in, lane_ok, out_ready,
        input  in_ready, out_valid, out_coeff, out_idx
    );

    modport slave (
        input  in_valid, coeff_in, lane_ok, out_ready,
        output in_ready, out_valid, out_coeff, out_idx
    );
endinterface

// File: rtl/coeff_collect.sv
// Collects range-checked candidates from six parse lanes into one NCOEF-entry
// polynomial, staged through a small multi-push / single-pop FIFO.
module coeff_collect #(
    parameter int NCOEF = 256,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           resetb,
    input  logic           start,
    output logic           busy,
    output logic           done,
    coeff_collect_if.slave bus
);
    localparam int LANES  = 6;
    localparam int COEF_W = 12;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int ACC_W  = $clog2(NCOEF + LANES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [7:0]        out_cnt_q, out_cnt_d;
    logic              done_q, done_d;
    logic [COEF_W-1:0] mem_q [DEPTH];

    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              pop;
    logic              pop_last;
    logic [2:0]        push_n;
    logic [COEF_W-1:0] slot [LANES];

    assign in_ready  = (state_q == COLLECT) && (occ_q <= OCC_W'(DEPTH - LANES));
    assign out_valid = (occ_q != '0);
    // A word arriving with start is discarded along with the flushed polynomial.
    assign accept    = bus.in_valid && in_ready && !start;
    assign pop       = out_valid && bus.out_ready;
    assign pop_last  = pop && (state_q == DRAIN) && (out_cnt_q == 8'(NCOEF - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_coeff = out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_idx   = out_cnt_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    // Compact accepted lanes low-to-high, truncating at the polynomial boundary.
    always_comb begin
        push_n = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            if (accept && bus.lane_ok[k] &&
                (acc_cnt_q + ACC_W'(push_n) < ACC_W'(NCOEF))) begin
                slot[push_n] = bus.coeff_in[COEF_W*k +: COEF_W];
                push_n       = push_n + 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        acc_cnt_d = acc_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        if (start) begin
            state_d   = COLLECT;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
            acc_cnt_d = '0;
            out_cnt_d = '0;
        end else begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(push_n);
            rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
            occ_d     = occ_q + OCC_W'(push_n) - OCC_W'(pop);
            acc_cnt_d = acc_cnt_q + ACC_W'(push_n);
            if (pop) begin
                out_cnt_d = out_cnt_q + 8'd1;
            end
            unique case (state_q)
                COLLECT: begin
                    if (acc_cnt_d == ACC_W'(NCOEF)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            acc_cnt_q <= acc_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
        end
    end

    // Staging storage carries data only; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (3'(i) < push_n) begin
                mem_q[wr_ptr_q + PTR_W'(i)] <= slot[i];
            end
        end
    end
endmodule

// File: tb/tb_coeff_collect.sv
// Randomized scoreboard bench for coeff_collect against a queue-based polynomial model.
module tb_coeff_collect;
    localparam int NCOEF = 256;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic resetb;
    logic start;
    logic busy;
    logic done;

    coeff_collect_if bus();

    coeff_collect #(.NCOEF(NCOEF), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetb (resetb),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] coeff;
        logic [7:0]  idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    bit   m_busy = 0;
    bit   m_done = 0;
    int   m_acc = 0;
    int   m_pops = 0;
    int   occ = 0;
    int   done_seen = 0;
    int   pops_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a polynomial is the first NCOEF accepted lanes in arrival order.
    initial begin
        int   pushes;
        bit   rdy;
        bit   pop;
        exp_t e;
        forever begin
            @(posedge clk);
            if (resetb) begin
                m_busy = 0; m_done = 0; m_acc = 0; m_pops = 0; occ = 0;
                q.delete();
            end else if (start) begin
                m_busy = 1; m_done = 0; m_acc = 0; m_pops = 0; occ = 0;
                q.delete();
            end else begin
                pushes = 0;
                rdy    = m_busy && (m_acc < NCOEF) && (DEPTH - occ >= 6);
                pop    = (occ > 0) && bus.out_ready;
                m_done = 0;
                if (pop) begin
                    if (m_pops == NCOEF - 1) begin
                        m_done = 1;
                        m_busy = 0;
                    end
                    m_pops++;
                end
                if (bus.in_valid && rdy) begin
                    for (int k = 0; k < 6; k++) begin
                        if (bus.lane_ok[k] && m_acc < NCOEF) begin
                            e.coeff = bus.coeff_in[12*k +: 12];
                            e.idx   = 8'(m_acc);
                            q.push_back(e);
                            m_acc++;
                            pushes++;
                        end
                    end
                end
                occ = occ + pushes - int'(pop);
            end
        end
    end

    // Monitor: compares DUT outputs with the model and retires consumed entries.
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ev = (occ > 0);
                check("in_ready", int'(bus.in_ready), int'(m_busy && (m_acc < NCOEF) && (DEPTH - occ >= 6)));
                check("out_valid", int'(bus.out_valid), int'(ev));
                check("busy", int'(busy), int'(m_busy));
                check("done", int'(done), int'(m_done));
                check("out_idx", int'(bus.out_idx), m_pops % 256);
                if (done) done_seen++;
                if (ev) begin
                    if (q.size() == 0) begin
                        check("scoreboard_empty", 1, 0);
                    end else begin
                        check("out_coeff", int'(bus.out_coeff), int'(q[0].coeff));
                        check("head_idx", int'(bus.out_idx), int'(q[0].idx));
                        if (bus.out_ready && !start && !resetb) begin
                            void'(q.pop_front());
                            pops_seen++;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        bus.in_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic drive_word(input logic [5:0] ok);
        bus.in_valid = 1'b1;
        bus.lane_ok  = ok;
        for (int k = 0; k < 6; k++) bus.coeff_in[12*k +: 12] = 12'($urandom);
    endtask

    task automatic run_poly(input bit rnd, input string tag);
        int d0;
        int p0;
        bit got;
        d0 = done_seen;
        p0 = pops_seen;
        got = 0;
        pulse_start();
        for (int n = 0; n < 5000 && !got; n++) begin
            if (m_acc < NCOEF && (!rnd || $urandom_range(0, 9) < 7))
                drive_word(rnd ? 6'($urandom) : 6'h3f);
            else
                bus.in_valid = 1'b0;
            bus.out_ready = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
            step();
            if (done) got = 1;
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        check({tag, "_done_seen"}, int'(got), 1);
        check({tag, "_done_pulses"}, done_seen - d0, 1);
        check({tag, "_pops"}, pops_seen - p0, NCOEF);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        resetb = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.coeff_in = '0;
        bus.lane_ok = '0;
        bus.out_ready = 1'b0;
        step();
        mon_en = 1;
        step();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_coeff", int'(bus.out_coeff), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        start = 1'b1;
        step();
        check("rst_dominates_start", int'(busy), 0);
        start = 1'b0;
        resetb = 1'b0;
        step();

        // lanes 1..6 in order
        p0 = pops_seen;
        pulse_start();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.lane_ok = 6'h3f;
        for (int k = 0; k < 6; k++) bus.coeff_in[12*k +: 12] = 12'(k + 1);
        step();
        bus.in_valid = 1'b0;
        repeat (8) step();
        check("r035_pops", pops_seen - p0, 6);

        // sparse lane mask
        p0 = pops_seen;
        pulse_start();
        bus.in_valid = 1'b1;
        bus.lane_ok = 6'b101001;
        for (int k = 0; k < 6; k++) bus.coeff_in[12*k +: 12] = 12'((k + 1) * 16);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        check("r036_pops", pops_seen - p0, 3);

        // backpressure fills FIFO to 12
        p0 = pops_seen;
        pulse_start();
        bus.out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            drive_word(6'h3f);
            step();
        end
        check("r037_in_ready_low", int'(bus.in_ready), 0);
        check("r037_out_idx_held", int'(bus.out_idx), 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (16) step();
        check("r037_pops", pops_seen - p0, 12);

        run_poly(0, "r038");

        // reset during DRAIN with entries staged
        pulse_start();
        for (int n = 0; n < 1000 && m_acc < NCOEF; n++) begin
            drive_word(6'h3f);
            bus.out_ready = (occ > 10);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        check("r039_staged", int'(bus.out_valid), 1);
        check("r039_busy_before", int'(busy), 1);
        d0 = done_seen;
        resetb = 1'b1;
        step();
        resetb = 1'b0;
        check("r039_out_valid", int'(bus.out_valid), 0);
        check("r039_busy", int'(busy), 0);
        check("r039_out_coeff", int'(bus.out_coeff), 0);
        check("r039_out_idx", int'(bus.out_idx), 0);
        repeat (5) step();
        check("r039_no_done", done_seen - d0, 0);

        // restart while busy at out_cnt = 100
        pulse_start();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 1000 && m_pops < 100; n++) begin
            if (m_acc < NCOEF) drive_word(6'h3f);
            else bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        check("r040_idx_before_restart", int'(bus.out_idx), 100);
        run_poly(0, "r040");

        for (int r = 0; r < 3; r++) run_poly(1, "rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
